regf_writeback: RTL
===================

# regf_writeback

Write-side collector for the integer register file. It gathers result writes from several execution sources, including the ALU, load unit and multi-cycle mul/div. It buffers them in a small in-order FIFO and drains them at one write per cycle onto the register file's single registered write port (`w_enable`/`w_addr`/`w_data`). It also publishes a per-register pending-write vector for the issue/hazard logic.

## Interface
- `NSRC`, 3, number of write sources; index 0 has the highest priority (oldest within a cycle).
- `DEPTH`, 4, FIFO entries; must satisfy `DEPTH >= NSRC` (elaboration-time check).
- `clk`  in  1  clock.
- `rst`  in  1  reset: one clock; reset is asynchronous and active-high.
- `src_valid`  in  NSRC  a source offers a write.
- `src_ready`  out  NSRC  the offered write is accepted this cycle when `src_valid && src_ready`.
- `src_addr`  in  NSRC×5  destination register per source.
- `src_data`  in  NSRC×32  write data per source.
- `w_enable`  out  1  register-file write strobe.
- `w_addr`  out  5  register-file write address.
- `w_data`  out  32  register-file write data.
- `pending`  out  32  bit r is set while an accepted write to r has not yet been presented on `w_*`.

## Operation
- `src_ready[i] = !rst && (free >= NSRC)`.
  - `free = DEPTH - count`, where `count` is the FIFO occupancy at the start of the cycle.
  - All sources therefore see the same ready.
- Each cycle, all handshaken sources are accepted together.
  - Push order is ascending source index, so lower index is treated as older.
- Writes to x0 are handshaken normally, then dropped: they are never enqueued and never set `pending`.
- Output stage:
  - If the FIFO is non-empty, the head pops into `w_*`.
  - If the FIFO is empty, the lowest-index accepted non-x0 write goes straight into `w_*`, and the remaining accepted writes enqueue.
  - If nothing is available, `w_enable` goes to 0. `w_addr`/`w_data` hold their last values.
- Exactly one write leaves per cycle when any is available. The register file never back-pressures.
- Program order per register is preserved: same-address writes leave in acceptance order, so the last one wins in the register file.
- `pending[r]` is the OR over valid FIFO entries with addr r, plus accepted-this-cycle entries not yet registered. It is combinational and must rise in the acceptance cycle.
  - The entry in the `w_*` register does not count: it commits at that edge.
- Arithmetic:
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH (DEPTH is a power of two).
  - `count` is log2(DEPTH)+1 bits.

## Timing
- Reset values: `w_enable`=0, `w_addr`=0, `w_data`=0, FIFO empty, `pending`=0, `src_ready`=0 while `rst` is high.
- Latency is 1 cycle, minimum: a write accepted in cycle N with an empty FIFO shows `w_enable`=1 in cycle N+1.
- A FIFO at position k (0 = head) leaves in cycle N+1+k.
- Full boundary:
  - When `free < NSRC`, all `src_ready` are 0 even if a single source is valid.
  - Ready reasserts the cycle after a pop restores `free >= NSRC`.
- A simultaneous push and pop in the same cycle updates `count` by the number pushed minus one.
- Reset mid-operation discards all buffered writes.
  - `w_enable` drops asynchronously.
  - No partial write reaches the register file.

## Configuration
- `REGF_WB_BYPASS_EN` defined:
  - Adds input `byp_addr[4:0]` and outputs `byp_hit`/`byp_data[31:0]`.
  - `byp_hit`=1 when any FIFO entry or accepted-this-cycle write targets `byp_addr` (≠0).
  - `byp_data` is the youngest such value, for operand forwarding past the register file's registered read.
- Not defined: those ports do not exist, and `pending` is the only hazard output.

## Structure
- Shared package `regf_pkg`:
  - `wb_req_t` struct {`addr[4:0]`, `data[31:0]`}.
  - Constants `REG_NUM`=32 and `XLEN`=32.
- One sub-module: `regf_wb_fifo`, a multi-push (≤NSRC), single-pop circular buffer exporting per-entry valid/addr for `pending` and bypass.
- Arbitration, direct-to-output path and pending OR live in `regf_writeback`.

## Test plan
- Single ALU write (x5, 0x1234), FIFO empty:
  - `pending[5]`=1 in cycle N.
  - `w_enable`=1, `w_addr`=5, `w_data`=0x1234 in N+1.
  - `pending[5]`=0 in N+1.
- All three sources valid in one cycle (x1/0xA, x2/0xB, x3/0xC):
  - Writes appear on consecutive cycles N+1..N+3 in the order x1, x2, x3.
- Sources 0 and 2 both write x7 (0x11, 0x22) in one cycle:
  - Outputs are 0x11 then 0x22.
  - `pending[7]` stays 1 until the 0x22 entry is popped.
- Write to x0 with value 0xFFFFFFFF:
  - Handshake completes.
  - `w_enable` never asserts for it; `pending`=0.
- Saturate: hold all sources valid continuously.
  - `src_ready` drops to 0 exactly when `free < 3`.
  - No write is lost or duplicated over 50 cycles (scoreboard compare).
- Assert `rst` with 3 entries buffered:
  - `w_enable`=0 immediately.
  - After release, `pending`=0 and the first new write has 1-cycle latency.

Source files
------------

// File: rtl/regf_pkg.sv
// ============================================================================
//  Module      : regf_pkg
//  Description : Shared types and constants for the integer register-file
//                write-back collector (regf_writeback, regf_wb_fifo).
//  Contents    : REG_NUM  - number of architectural integer registers
//                XLEN     - register width in bits
//                wb_req_t - one register write {addr, data}
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regf_pkg;

    localparam int REG_NUM = 32;
    localparam int XLEN    = 32;

    typedef struct packed {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage : regf_pkg

`default_nettype wire

// File: rtl/regf_wb_fifo.sv
// ============================================================================
//  Module      : regf_wb_fifo
//  Description : In-order circular buffer accepting up to NSRC pushes and one
//                pop per cycle. Entries are exported in age order (index 0 is
//                the head) so the parent can build hazard/bypass views.
//  Ports       : clk, rst        - clock, async active-high reset
//                push_i          - per-lane push strobe (lanes pushed in
//                                  ascending index order)
//                push_req_i      - per-lane write request
//                pop_i           - remove head (caller guarantees non-empty)
//                count_o         - occupancy at the start of the cycle
//                ent_valid_o     - per-age-slot valid
//                ent_addr_o      - per-age-slot destination register
//                head_o          - oldest entry
//                ent_data_o      - per-age-slot data (REGF_WB_BYPASS_EN only)
//  Config      : REGF_WB_BYPASS_EN adds ent_data_o
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regf_wb_fifo
    import regf_pkg::*;
#(
    parameter int  NSRC  = 3,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic    [NSRC-1:0]           push_i,
    input  wb_req_t [NSRC-1:0]           push_req_i,
    input  logic                         pop_i,
    output logic    [CNT_W-1:0]          count_o,
    output logic    [DEPTH-1:0]          ent_valid_o,
    output logic    [DEPTH-1:0][4:0]     ent_addr_o,
`ifdef REGF_WB_BYPASS_EN
    output logic    [DEPTH-1:0][XLEN-1:0] ent_data_o,
`endif
    output wb_req_t                      head_o
);

    wb_req_t [DEPTH-1:0] mem_q, mem_d;
    logic    [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic    [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic    [CNT_W-1:0] count_q, count_d;
    logic    [CNT_W-1:0] npush;
    logic    [PTR_W-1:0] slot;
    logic    [PTR_W-1:0] age_idx;

    // Active lanes are packed contiguously starting at the write pointer,
    // keeping lower lanes older than higher lanes.
    always_comb begin
        mem_d = mem_q;
        npush = '0;
        slot  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (push_i[i]) begin
                slot        = wr_ptr_q + npush[PTR_W-1:0];
                mem_d[slot] = push_req_i[i];
                npush       = npush + CNT_W'(1);
            end
        end
        wr_ptr_d = wr_ptr_q + npush[PTR_W-1:0];
        rd_ptr_d = pop_i ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d  = count_q + npush - (pop_i ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Age-ordered view: slot k holds the k-th oldest entry.
    always_comb begin
        age_idx     = '0;
        ent_valid_o = '0;
        ent_addr_o  = '0;
`ifdef REGF_WB_BYPASS_EN
        ent_data_o  = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            age_idx        = rd_ptr_q + PTR_W'(k);
            ent_valid_o[k] = CNT_W'(k) < count_q;
            ent_addr_o[k]  = mem_q[age_idx].addr;
`ifdef REGF_WB_BYPASS_EN
            ent_data_o[k]  = mem_q[age_idx].data;
`endif
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : regf_wb_fifo

`default_nettype wire

// File: rtl/regf_writeback.sv
// ============================================================================
//  Module      : regf_writeback
//  Description : Collects register writes from NSRC execution sources,
//                buffers them in order and drains one per cycle onto the
//                register file's registered write port. Publishes a
//                per-register pending-write vector for hazard detection.
//  Ports       : clk, rst      - clock, async active-high reset
//                src_valid_i   - per-source write offer
//                src_ready_o   - common acceptance (all sources see same)
//                src_addr_i    - per-source destination register
//                src_data_i    - per-source write data
//                w_enable_o    - register-file write strobe (registered)
//                w_addr_o      - register-file write address (registered)
//                w_data_o      - register-file write data (registered)
//                pending_o     - bit r set while a write to r is in flight
//                byp_addr_i    - bypass lookup register (REGF_WB_BYPASS_EN)
//                byp_hit_o     - in-flight write found  (REGF_WB_BYPASS_EN)
//                byp_data_o    - youngest in-flight value (REGF_WB_BYPASS_EN)
//  Config      : REGF_WB_BYPASS_EN enables the operand-bypass lookup port
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regf_writeback
    import regf_pkg::*;
#(
    parameter int NSRC  = 3,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NSRC-1:0]           src_valid_i,
    output logic [NSRC-1:0]           src_ready_o,
    input  logic [NSRC-1:0][4:0]      src_addr_i,
    input  logic [NSRC-1:0][XLEN-1:0] src_data_i,
    output logic                      w_enable_o,
    output logic [4:0]                w_addr_o,
    output logic [XLEN-1:0]           w_data_o,
`ifdef REGF_WB_BYPASS_EN
    input  logic [4:0]                byp_addr_i,
    output logic                      byp_hit_o,
    output logic [XLEN-1:0]           byp_data_o,
`endif
    output logic [REG_NUM-1:0]        pending_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    generate
        if (DEPTH < NSRC) begin : g_depth_chk
            $error("regf_writeback: DEPTH must be >= NSRC");
        end
        if ((1 << $clog2(DEPTH)) != DEPTH) begin : g_pow2_chk
            $error("regf_writeback: DEPTH must be a power of two");
        end
    endgenerate

    logic    [CNT_W-1:0]      fifo_count;
    logic    [CNT_W-1:0]      free_slots;
    logic                     fifo_empty;
    logic                     accept_en;
    logic    [NSRC-1:0]       keep;
    logic    [NSRC-1:0]       push;
    wb_req_t [NSRC-1:0]       src_req;
    wb_req_t                  direct_req;
    logic                     direct_found;
    logic    [DEPTH-1:0]      ent_valid;
    logic    [DEPTH-1:0][4:0] ent_addr;
    wb_req_t                  head;
    logic    [REG_NUM-1:0]    pending;

    logic                     w_enable_q, w_enable_d;
    logic    [4:0]            w_addr_q,   w_addr_d;
    logic    [XLEN-1:0]       w_data_q,   w_data_d;

    assign fifo_empty  = (fifo_count == '0);
    assign free_slots  = CNT_W'(DEPTH) - fifo_count;
    // Accept only when every source could push at once, so no per-source
    // arbitration against remaining space is needed.
    assign accept_en   = !rst && (free_slots >= CNT_W'(NSRC));
    assign src_ready_o = {NSRC{accept_en}};

    // Accepted writes: x0 is handshaken but discarded. With an empty FIFO the
    // oldest surviving write skips the buffer and goes straight to w_*.
    always_comb begin
        keep         = '0;
        push         = '0;
        src_req      = '0;
        direct_req   = '0;
        direct_found = 1'b0;
        pending      = '0;
        for (int i = 0; i < NSRC; i++) begin
            src_req[i].addr = src_addr_i[i];
            src_req[i].data = src_data_i[i];
            keep[i]         = src_valid_i[i] && accept_en && (src_addr_i[i] != 5'd0);
            if (keep[i]) begin
                pending[src_addr_i[i]] = 1'b1;
                if (fifo_empty && !direct_found) begin
                    direct_found = 1'b1;
                    direct_req   = src_req[i];
                end else begin
                    push[i] = 1'b1;
                end
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (ent_valid[j]) begin
                pending[ent_addr[j]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_enable_d = !fifo_empty || direct_found;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        if (!fifo_empty) begin
            w_addr_d = head.addr;
            w_data_d = head.data;
        end else if (direct_found) begin
            w_addr_d = direct_req.addr;
            w_data_d = direct_req.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_enable_q <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
        end else begin
            w_enable_q <= w_enable_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
        end
    end

`ifdef REGF_WB_BYPASS_EN
    logic [DEPTH-1:0][XLEN-1:0] ent_data;

    // Scan oldest to youngest so the last match is the youngest value:
    // buffered entries first, then this cycle's accepted writes.
    always_comb begin
        byp_hit_o  = 1'b0;
        byp_data_o = '0;
        if (byp_addr_i != 5'd0) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (ent_valid[j] && (ent_addr[j] == byp_addr_i)) begin
                    byp_hit_o  = 1'b1;
                    byp_data_o = ent_data[j];
                end
            end
            for (int i = 0; i < NSRC; i++) begin
                if (keep[i] && (src_addr_i[i] == byp_addr_i)) begin
                    byp_hit_o  = 1'b1;
                    byp_data_o = src_data_i[i];
                end
            end
        end
    end
`endif

    regf_wb_fifo #(
        .NSRC  (NSRC),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_req_i  (src_req),
        .pop_i       (!fifo_empty),
        .count_o     (fifo_count),
        .ent_valid_o (ent_valid),
        .ent_addr_o  (ent_addr),
`ifdef REGF_WB_BYPASS_EN
        .ent_data_o  (ent_data),
`endif
        .head_o      (head)
    );

    assign w_enable_o = w_enable_q;
    assign w_addr_o   = w_addr_q;
    assign w_data_o   = w_data_q;
    assign pending_o  = pending;

endmodule : regf_writeback

`default_nettype wire
